// File: rtl/game_of_life_axil_regfile_pkg.sv
// game_of_life AXI4-Lite register file: shared response codes and helpers.
// Provides strb_merge (byte-lane merge) and addr_to_idx (byte address -> word index).
package game_of_life_axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   function automatic logic [31:0] strb_merge(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = old;
      for (int j = 0; j < 4; j++) begin
         if (strb[j]) res[8*j +: 8] = data[8*j +: 8];
      end
      return res;
   endfunction

   function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

endpackage

// File: rtl/game_of_life_axil_regfile_if.sv
// AXI4-Lite bus bundle for the game_of_life register file.
// Ports: AW/W/B/AR/R channels; master modport drives requests, slave answers.
interface game_of_life_axil_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]              AWPROT;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]              ARPROT;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, input AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARPROT, ARVALID, input ARREADY,
      input RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWPROT, AWVALID, output AWREADY,
      input WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARPROT, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );

endinterface

// File: rtl/game_of_life_axil_regfile.sv
// AXI4-Lite slave register file: RW/RO/pulse registers with byte strobes.
// Ports: ACLK, ARESETN, axi (slave), reg_out, ro_in, pulse_out, wr_strobe.
module game_of_life_axil_regfile
   import game_of_life_axil_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = 8'hC0,
   parameter int                  PULSE_REG  = 1
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   game_of_life_axil_if.slave             axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
   output logic [DATA_WIDTH-1:0]          pulse_out,
   output logic [NUM_REGS-1:0]            wr_strobe
);

   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

   logic                    aw_full;
   logic                    w_full;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;

   logic                    aw_hs;
   logic                    w_hs;
   logic                    ar_hs;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   wa;
   logic [DATA_WIDTH-1:0]   wd;
   logic [DATA_WIDTH/8-1:0] ws;
   logic [31:0]             w_idx;
   logic [31:0]             r_idx;
   logic                    w_ok;
   logic                    rd_ok;
   logic [DATA_WIDTH-1:0]   rd_data;

   assign axi.AWREADY = !aw_full && !axi.BVALID;
   assign axi.WREADY  = !w_full && !axi.BVALID;
   assign axi.ARREADY = !axi.RVALID;

   assign aw_hs  = axi.AWVALID && axi.AWREADY;
   assign w_hs   = axi.WVALID && axi.WREADY;
   assign ar_hs  = axi.ARVALID && axi.ARREADY;

   // Commit as soon as both halves exist, buffered or arriving now.
   assign commit = (aw_full || aw_hs) && (w_full || w_hs);

   assign wa    = aw_full ? aw_addr_q : axi.AWADDR;
   assign wd    = w_full ? w_data_q : axi.WDATA;
   assign ws    = w_full ? w_strb_q : axi.WSTRB;
   assign w_idx = addr_to_idx(32'(wa));
   assign r_idx = addr_to_idx(32'(axi.ARADDR));

   // Writable target: in range and not read-only (pulse reg counts).
   always_comb begin
      w_ok = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == 32'(i) && !RO_MASK[i]) w_ok = 1'b1;
      end
   end

   always_comb begin
      rd_ok   = 1'b0;
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_idx == 32'(i)) begin
            rd_ok = 1'b1;
            if (RO_MASK[i])
               rd_data = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
            else if (i != PULSE_REG)
               rd_data = regs[i];
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_full    <= 1'b0;
         w_full     <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         axi.BVALID <= 1'b0;
         axi.BRESP  <= AXI_RESP_OKAY;
         pulse_out  <= '0;
         wr_strobe  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= '0;
         pulse_out <= '0;
         if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
         if (commit) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            axi.BVALID <= 1'b1;
            axi.BRESP  <= w_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (w_idx == 32'(i) && !RO_MASK[i]) begin
                  wr_strobe[i] <= 1'b1;
                  if (i == PULSE_REG)
                     pulse_out <= strb_merge('0, wd, ws);
                  else
                     regs[i] <= strb_merge(regs[i], wd, ws);
               end
            end
         end else begin
            if (aw_hs) begin
               aw_full   <= 1'b1;
               aw_addr_q <= axi.AWADDR;
            end
            if (w_hs) begin
               w_full   <= 1'b1;
               w_data_q <= axi.WDATA;
               w_strb_q <= axi.WSTRB;
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         axi.RVALID <= 1'b0;
         axi.RDATA  <= '0;
         axi.RRESP  <= AXI_RESP_OKAY;
      end else if (ar_hs) begin
         axi.RVALID <= 1'b1;
         axi.RDATA  <= rd_data;
         axi.RRESP  <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (axi.RVALID && axi.RREADY) begin
         axi.RVALID <= 1'b0;
      end
   end

   // Only RW registers are exported; RO and pulse slices read as zero.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
         (RO_MASK[g] || g == PULSE_REG) ? '0 : regs[g];
   end

endmodule

// File: tb/tb_game_of_life_axil_regfile.sv
// Self-checking bench for game_of_life_axil_regfile.
// Directed cases plus random traffic against a register-array model.
module tb_game_of_life_axil_regfile;
   import game_of_life_axil_pkg::*;

   logic         ACLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic [255:0] reg_out;
   logic [255:0] ro_in;
   logic [31:0]  pulse_out;
   logic [7:0]   wr_strobe;

   game_of_life_axil_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi ();

   game_of_life_axil_regfile dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .axi       (axi),
      .reg_out   (reg_out),
      .ro_in     (ro_in),
      .pulse_out (pulse_out),
      .wr_strobe (wr_strobe)
   );

   always #5 ACLK = ~ACLK;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] mregs [8];
   logic [5:0]  pend_addr = '0;
   logic [31:0] pend_data = '0;
   logic [3:0]  pend_strb = '0;
   bit          mon_en = 1'b0;
   logic        bv_prev = 1'b0;
   logic [1:0]  exp_bresp = 2'b00;
   int          pulse_cycles = 0;
   logic [31:0] pulse_val = '0;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] s);
      logic [31:0] m;
      for (int j = 0; j < 4; j++) m[8*j +: 8] = s[j] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic bit m_ok(input logic [5:0] a);
      int idx;
      idx = int'(a >> 2);
      return idx < 8 && idx != 6 && idx != 7;
   endfunction

   function automatic logic [31:0] m_read(input logic [5:0] a);
      int idx;
      idx = int'(a >> 2);
      if (idx >= 8) return 32'h0;
      if (idx >= 6) return ro_in[idx*32 +: 32];
      if (idx == 1) return 32'h0;
      return mregs[idx];
   endfunction

   function automatic logic [255:0] m_regout();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         if (i != 1 && i < 6) v[i*32 +: 32] = mregs[i];
      return v;
   endfunction

   // Every cycle: apply the pending write when BVALID rises, then compare.
   always @(negedge ACLK) begin
      logic [7:0]  es;
      logic [31:0] ep;
      int          idx;
      if (mon_en) begin
         es = '0;
         ep = '0;
         if (axi.BVALID && !bv_prev) begin
            idx = int'(pend_addr >> 2);
            if (m_ok(pend_addr)) begin
               exp_bresp = AXI_RESP_OKAY;
               es[idx] = 1'b1;
               if (idx == 1)
                  ep = pend_data & bmask(pend_strb);
               else
                  mregs[idx] = (mregs[idx] & ~bmask(pend_strb))
                             | (pend_data & bmask(pend_strb));
            end else begin
               exp_bresp = AXI_RESP_SLVERR;
            end
         end
         chk("wr_strobe", wr_strobe, es);
         chk("pulse_out", pulse_out, ep);
         chk("reg_out", reg_out, m_regout());
         if (axi.BVALID) chk("bresp", axi.BRESP, exp_bresp);
         if (pulse_out != 0) begin
            pulse_cycles++;
            pulse_val = pulse_out;
         end
      end
      bv_prev = axi.BVALID;
   end

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int awd,
                            input int wd, input int bd,
                            output int lat, output logic [1:0] br);
      bit aw_done;
      bit w_done;
      aw_done = 1'b0;
      w_done = 1'b0;
      pend_addr = a;
      pend_data = d;
      pend_strb = s;
      fork
         begin
            bit r;
            repeat (awd) begin @(posedge ACLK); #1; end
            axi.AWADDR = a;
            axi.AWVALID = 1'b1;
            for (int k = 0; k < 50 && !aw_done; k++) begin
               @(negedge ACLK);
               r = axi.AWREADY;
               @(posedge ACLK);
               #1;
               if (r) aw_done = 1'b1;
            end
            axi.AWVALID = 1'b0;
            if (!aw_done) chk("aw_timeout", 0, 1);
            for (int k = 0; k < 60 && !w_done; k++) begin
               @(negedge ACLK);
               if (!w_done) chk("awready_buffered", axi.AWREADY, 0);
            end
         end
         begin
            bit r;
            repeat (wd) begin @(posedge ACLK); #1; end
            axi.WDATA = d;
            axi.WSTRB = s;
            axi.WVALID = 1'b1;
            for (int k = 0; k < 50 && !w_done; k++) begin
               @(negedge ACLK);
               r = axi.WREADY;
               @(posedge ACLK);
               #1;
               if (r) w_done = 1'b1;
            end
            axi.WVALID = 1'b0;
            if (!w_done) chk("w_timeout", 0, 1);
            for (int k = 0; k < 60 && !aw_done; k++) begin
               @(negedge ACLK);
               if (!aw_done) chk("wready_buffered", axi.WREADY, 0);
            end
         end
      join
      lat = 0;
      while (!axi.BVALID && lat < 50) begin
         @(posedge ACLK);
         #1;
         lat++;
      end
      if (!axi.BVALID) chk("bvalid_timeout", 0, 1);
      br = axi.BRESP;
      repeat (bd) begin
         @(negedge ACLK);
         chk("bvalid_hold", axi.BVALID, 1);
         chk("awready_low_b", axi.AWREADY, 0);
         chk("wready_low_b", axi.WREADY, 0);
         @(posedge ACLK);
         #1;
      end
      axi.BREADY = 1'b1;
      @(posedge ACLK);
      #1;
      axi.BREADY = 1'b0;
      chk("bvalid_clear", axi.BVALID, 0);
   endtask

   task automatic axi_read(input logic [5:0] a, input int rd,
                           output logic [31:0] got, output logic [1:0] gr);
      logic [31:0] ed;
      logic [1:0]  er;
      bit          r;
      bit          done;
      ed = '0;
      er = '0;
      got = '0;
      gr = '0;
      done = 1'b0;
      axi.ARADDR = a;
      axi.ARVALID = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge ACLK);
         r = axi.ARREADY;
         if (r) begin
            ed = m_read(a);
            er = (a >> 2) < 8 ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
         end
         @(posedge ACLK);
         #1;
         if (r) done = 1'b1;
      end
      axi.ARVALID = 1'b0;
      if (!done) begin
         chk("ar_timeout", 0, 1);
      end else begin
         chk("rvalid", axi.RVALID, 1);
         chk("rdata", axi.RDATA, ed);
         chk("rresp", axi.RRESP, er);
         got = axi.RDATA;
         gr = axi.RRESP;
         repeat (rd) begin
            @(negedge ACLK);
            chk("rvalid_hold", axi.RVALID, 1);
            chk("arready_low", axi.ARREADY, 0);
            chk("rdata_hold", axi.RDATA, ed);
            @(posedge ACLK);
            #1;
         end
         axi.RREADY = 1'b1;
         @(posedge ACLK);
         #1;
         axi.RREADY = 1'b0;
         chk("rvalid_clear", axi.RVALID, 0);
      end
   endtask

   initial begin
      int          lat;
      logic [1:0]  br;
      logic [31:0] got;
      logic [1:0]  gr;
      logic [5:0]  ra;

      axi.AWADDR = '0;  axi.AWPROT = '0; axi.AWVALID = 1'b0;
      axi.WDATA = '0;   axi.WSTRB = '0;  axi.WVALID = 1'b0;
      axi.BREADY = 1'b0;
      axi.ARADDR = '0;  axi.ARPROT = '0; axi.ARVALID = 1'b0;
      axi.RREADY = 1'b0;
      ro_in = {8{32'h1234_5678}};
      for (int i = 0; i < 8; i++) mregs[i] = '0;

      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_awready", axi.AWREADY, 1);
      chk("rst_wready", axi.WREADY, 1);
      chk("rst_arready", axi.ARREADY, 1);
      chk("rst_bvalid", axi.BVALID, 0);
      chk("rst_rvalid", axi.RVALID, 0);
      chk("rst_rdata", axi.RDATA, 0);
      chk("rst_bresp", axi.BRESP, 0);
      chk("rst_rresp", axi.RRESP, 0);
      chk("rst_pulse", pulse_out, 0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_regout", reg_out, 0);
      ARESETN = 1'b1;
      mon_en = 1'b1;

      // Basic writes, single-cycle AW+W.
      foreach (mregs[i]) begin
         if (i == 0 || (i >= 2 && i <= 5)) begin
            axi_write(6'(i*4), 32'(i+1), 4'hF, 0, 0, 0, lat, br);
            chk("b_latency", lat, 0);
            chk("b_okay", br, AXI_RESP_OKAY);
         end
      end
      axi_read(6'h00, 0, got, gr);
      chk("rb_reg0", got, 32'h1);
      axi_read(6'h14, 0, got, gr);
      chk("rb_reg5", got, 32'h6);

      // Data three cycles ahead of address.
      axi_write(6'h0C, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, lat, br);
      chk("w_first_lat", lat, 0);
      chk("w_first_regout", reg_out[3*32 +: 32], 32'hDEAD_BEEF);
      axi_write(6'h0D, 32'h0BAD_F00D, 4'hF, 0, 2, 0, lat, br);
      chk("aw_first_regout", reg_out[3*32 +: 32], 32'h0BAD_F00D);

      // Byte strobes.
      axi_write(6'h08, 32'hAABB_CCDD, 4'hF, 0, 0, 0, lat, br);
      axi_write(6'h08, 32'h1122_3344, 4'b0101, 0, 0, 0, lat, br);
      axi_read(6'h08, 0, got, gr);
      chk("strb_merge", got, 32'hAA22_CC44);
      axi_write(6'h08, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, lat, br);
      chk("strb_zero", reg_out[2*32 +: 32], 32'hAA22_CC44);

      // Read-only and out-of-range.
      ro_in[6*32 +: 32] = 32'h0000_CAFE;
      axi_write(6'h18, 32'h5555_5555, 4'hF, 0, 0, 0, lat, br);
      chk("ro_slverr", br, AXI_RESP_SLVERR);
      axi_write(6'h3C, 32'h5555_5555, 4'hF, 0, 0, 0, lat, br);
      chk("oor_slverr", br, AXI_RESP_SLVERR);
      axi_read(6'h18, 0, got, gr);
      chk("ro_read", got, 32'h0000_CAFE);
      chk("ro_read_ok", gr, AXI_RESP_OKAY);
      axi_read(6'h3C, 0, got, gr);
      chk("oor_rresp", gr, AXI_RESP_SLVERR);

      // Pulse register.
      pulse_cycles = 0;
      axi_write(6'h04, 32'h5, 4'hF, 0, 0, 0, lat, br);
      repeat (3) @(posedge ACLK);
      #1;
      chk("pulse_cycles", pulse_cycles, 1);
      chk("pulse_val", pulse_val, 32'h5);
      axi_read(6'h04, 0, got, gr);
      chk("pulse_read", got, 32'h0);
      axi_write(6'h04, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, lat, br);
      repeat (2) @(posedge ACLK);
      #1;
      chk("pulse_masked", pulse_val, 32'h0000_FF00);

      // Backpressure on both channels.
      axi_write(6'h00, 32'h0F0F_0F0F, 4'hF, 0, 0, 4, lat, br);
      axi_read(6'h00, 4, got, gr);

      // Reset with an address buffered and a read pending.
      axi.AWADDR = 6'h08;
      axi.AWVALID = 1'b1;
      axi.ARADDR = 6'h00;
      axi.ARVALID = 1'b1;
      @(posedge ACLK);
      #1;
      axi.AWVALID = 1'b0;
      axi.ARVALID = 1'b0;
      chk("pre_rst_rvalid", axi.RVALID, 1);
      mon_en = 1'b0;
      ARESETN = 1'b0;
      #2;
      chk("mid_rst_awready", axi.AWREADY, 1);
      chk("mid_rst_rvalid", axi.RVALID, 0);
      chk("mid_rst_bvalid", axi.BVALID, 0);
      chk("mid_rst_regout", reg_out, 0);
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      bv_prev = 1'b0;
      mon_en = 1'b1;
      pend_addr = 6'h10;
      pend_data = 32'h77;
      pend_strb = 4'hF;
      axi.WDATA = 32'h77;
      axi.WSTRB = 4'hF;
      axi.WVALID = 1'b1;
      @(posedge ACLK);
      #1;
      axi.WVALID = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         chk("no_stale_aw", axi.BVALID, 0);
         chk("w_held", axi.WREADY, 0);
      end
      @(posedge ACLK);
      #1;
      axi.AWADDR = 6'h10;
      axi.AWVALID = 1'b1;
      @(posedge ACLK);
      #1;
      axi.AWVALID = 1'b0;
      chk("post_rst_bvalid", axi.BVALID, 1);
      axi.BREADY = 1'b1;
      @(posedge ACLK);
      #1;
      axi.BREADY = 1'b0;
      axi_read(6'h10, 0, got, gr);
      chk("post_rst_read", got, 32'h77);

      // Random traffic.
      for (int n = 0; n < 80; n++) begin
         ro_in = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
         ra = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            axi_write(ra, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), lat, br);
         else
            axi_read(ra, $urandom_range(0, 2), got, gr);
      end

      repeat (3) @(posedge ACLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
